// File: rtl/uart_tx_engine.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity, stop period, all timed in s_tick pulses.
// Define UART_TX_PARITY_EN to add a parity bit after the data bits (parity_odd selects odd parity).
module uart_tx_engine #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
`ifdef UART_TX_PARITY_EN
    input  logic            parity_odd,
`endif
    output logic            tx,
    output logic            busy,
    output logic            tx_done_tick
);

    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = (SMAX > 2) ? $clog2(SMAX) : 1;
    localparam int NW   = (DBIT > 2) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] OVS_LAST  = SW'(OVS - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    function automatic logic even_parity(input logic [DBIT-1:0] v);
        return ^v;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    // State, counters and the registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; tx is derived from the next state so the line changes with the state register.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    b_d     = din;
                    s_d     = '0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(din);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == OVS_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == OVS_LAST) begin
                        s_d = '0;
                        b_d = {1'b0, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == OVS_LAST) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        s_d     = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase

        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d ^ parity_odd;
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign tx           = tx_q;
    assign busy         = busy_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: expected frames are queued when a request is driven
// and compared against bits sampled mid-bit from the tx line; cycle-exact checks cover timing.
`timescale 1ns/1ps
module tb_uart_tx_engine;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int OVS     = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS       = 1 + DBIT + PB + 1;
    localparam int FRAME_TICKS = OVS * (1 + DBIT + PB) + SB_TICK;
    localparam int DONE_CYC    = FRAME_TICKS + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            s_tick;
    logic            tx_start;
    logic [DBIT-1:0] din;
    logic            parity_odd;
    logic            tx;
    logic            busy;
    logic            tx_done_tick;

    uart_tx_engine #(.DBIT(DBIT), .SB_TICK(SB_TICK), .OVS(OVS)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
`ifdef UART_TX_PARITY_EN
        .parity_odd   (parity_odd),
`endif
        .tx           (tx),
        .busy         (busy),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Tick generator: every clock when tick_div<=1, else one clock in tick_div.
    int tick_div = 1;
    int tick_cnt = 0;
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tick_cnt++;
            s_tick = (tick_div <= 1) ? 1'b1 : ((tick_cnt % tick_div) == 0);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_q[$];

    function automatic logic [15:0] build_frame(input logic [DBIT-1:0] d, input logic odd);
        logic [15:0] f;
        f = 16'h0000;
        for (int i = 0; i < DBIT; i++) f[1+i] = d[i];
        if (PB == 1) f[1+DBIT] = (^d) ^ odd;
        f[NBITS-1] = 1'b1;
        return f;
    endfunction

    function automatic logic exp_tx(input int c, input logic [DBIT-1:0] d, input logic odd);
        int k;
        if (c < 1) return 1'b1;
        if (c <= OVS) return 1'b0;
        k = c - OVS - 1;
        if (k < OVS * DBIT) return d[k / OVS];
        k = k - OVS * DBIT;
        if (PB == 1 && k < OVS) return (^d) ^ odd;
        return 1'b1;
    endfunction

    // Monitor: frame detection, mid-bit sampling, done counting and busy-tick accounting.
    logic        in_frame   = 1'b0;
    int          tick_idx   = 0;
    int          bits_got   = 0;
    int          frame_cnt  = 0;
    int          done_cnt   = 0;
    int          busy_ticks = 0;
    int          last_ticks = 0;
    logic [15:0] got        = 16'h0000;
    int          start_cyc_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame   = 1'b0;
                busy_ticks = 0;
            end else begin
                if (tx_done_tick) begin
                    done_cnt++;
                    last_ticks = busy_ticks;
                    busy_ticks = 0;
                end
                if (busy && s_tick) busy_ticks++;
                if (!in_frame && tx === 1'b0) begin
                    in_frame = 1'b1;
                    tick_idx = 0;
                    bits_got = 0;
                    got      = 16'h0000;
                    frame_cnt++;
                    start_cyc_q.push_back(cyc);
                end
                if (in_frame && s_tick) begin
                    if ((tick_idx % OVS) == (OVS / 2 - 1)) begin
                        got[bits_got] = tx;
                        bits_got++;
                    end
                    tick_idx++;
                    if (bits_got == NBITS) begin
                        in_frame = 1'b0;
                        check_eq("sb_nonempty", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) check_eq("frame_bits", got, exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [DBIT-1:0] d);
        @(negedge clk);
        din      = d;
        tx_start = 1'b1;
        exp_q.push_back(build_frame(d, parity_odd));
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic run_directed(input logic [DBIT-1:0] d, input logic odd);
        int base_done;
        base_done = done_cnt;
        @(negedge clk);
        din        = d;
        parity_odd = odd;
        tx_start   = 1'b1;
        exp_q.push_back(build_frame(d, odd));
        for (int c = 1; c <= DONE_CYC; c++) begin
            @(negedge clk);
            if (c == 1) tx_start = 1'b0;
            check_eq("dir_tx", tx, exp_tx(c, d, odd));
            check_eq("dir_busy", busy, c < DONE_CYC);
            check_eq("dir_done", tx_done_tick, c == DONE_CYC);
        end
        @(negedge clk);
        check_eq("dir_ticks", last_ticks, FRAME_TICKS);
        check_eq("dir_done_cnt", done_cnt - base_done, 1);
    endtask

    initial begin
        int base_done;
        int base_frames;
        int n;
        int len;

        reset      = 1'b1;
        tx_start   = 1'b0;
        din        = '0;
        parity_odd = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", tx_done_tick, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame with s_tick tied high.
        run_directed(8'hA5, 1'b0);

        // Reset in the middle of DATA, then a fresh frame.
        base_done = done_cnt;
        send_frame(8'hA5);
        repeat (39) @(negedge clk);
        check_eq("pre_rst_tx", tx, exp_tx(40, 8'hA5, 1'b0));
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_eq("arst_tx", tx, 1);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", tx_done_tick, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("arst_no_done", done_cnt - base_done, 0);
        run_directed(8'h96, 1'b0);

        // Gapped ticks: one s_tick every 10 clocks.
        tick_div   = 10;
        parity_odd = 1'b0;
        base_done  = done_cnt;
        repeat (12) @(negedge clk);
        send_frame(8'h3C);
        n = 0;
        while (tx !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        len = 0;
        while (tx === 1'b1 && len < 4000) begin
            @(negedge clk);
            len++;
        end
        check_eq("gap_high_run", len, 4 * OVS * 10);
        len = 0;
        while (tx === 1'b0 && len < 4000) begin
            @(negedge clk);
            len++;
        end
        check_eq("gap_low_run", len, (2 + PB) * OVS * 10);
        repeat (2000) @(negedge clk);
        check_eq("gap_done_cnt", done_cnt - base_done, 1);
        check_eq("gap_ticks", last_ticks, FRAME_TICKS);
        tick_div = 1;
        repeat (3) @(negedge clk);

        // Requests during DATA and in the final STOP cycle are ignored; din changes do not leak in.
        base_done   = done_cnt;
        base_frames = frame_cnt;
        send_frame(8'h00);
        din = 8'hFF;
        repeat (49) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (FRAME_TICKS - 51) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (200) @(negedge clk);
        check_eq("ign_done_cnt", done_cnt - base_done, 1);
        check_eq("ign_frame_cnt", frame_cnt - base_frames, 1);
        check_eq("ign_busy", busy, 0);
        check_eq("ign_tx", tx, 1);

        // Back-to-back frames with tx_start held high.
        base_done   = done_cnt;
        base_frames = frame_cnt;
        start_cyc_q.delete();
        @(negedge clk);
        din      = 8'h55;
        tx_start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(build_frame(8'h55, parity_odd));
        repeat (2 * DONE_CYC) @(negedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (DONE_CYC + 20) @(negedge clk);
        check_eq("b2b_done_cnt", done_cnt - base_done, 3);
        check_eq("b2b_frame_cnt", frame_cnt - base_frames, 3);
        check_eq("b2b_starts", start_cyc_q.size(), 3);
        if (start_cyc_q.size() == 3) begin
            check_eq("b2b_gap1", start_cyc_q[1] - start_cyc_q[0], DONE_CYC);
            check_eq("b2b_gap2", start_cyc_q[2] - start_cyc_q[1], DONE_CYC);
        end

`ifdef UART_TX_PARITY_EN
        run_directed(8'h07, 1'b0);
        run_directed(8'h07, 1'b1);
`endif

        repeat (5) @(negedge clk);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
